fwd_ctrl: RTL and testbench

Hazard and forwarding controller that sits directly upstream of the register file in the 4-stage pipeline (ID, EX, MEM, WB). It tracks the destination registers of in-flight instructions and drives the register file's `reg_forward_1`/`reg_forward_2` selects. It stalls decode when a source register is still being produced in EX or MEM, and supplies the WB-stage write controls (`wr`, `wrn`, `wr0`) to the register file.

---
 rtl/fwd_ctrl.sv | 128 ++++++++++++
 tb/tb_fwd_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_ctrl
//
// Hazard and forwarding controller for a 4-stage pipeline (ID, EX, MEM, WB).
// It tracks the destinations of the instructions in EX, MEM and WB. It stalls
// decode while a source operand is still being produced in EX or MEM. It
// selects the register-file bypass for operands produced by the instruction
// in WB, and it drives the WB write controls to the register file.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid                     a valid instruction is in ID
//   id_use_1/2, rn_1/2           ID source enables and register numbers
//   id_wr, id_wrn, id_wr0        ID destination: general port / R0 port
//   flush                        kill the instructions in ID and EX
//   reg_forward_1/2              operand forward selects to the register file
//   stall                        hold IF/ID and insert a bubble into EX
//   wb_wr, wb_wrn, wb_wr0        register-file write controls from WB
//   stall_cnt                    saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_ctrl #(
   parameter int unsigned                 REG_NUM_WIDTH        = 4,
   parameter int unsigned                 REG_FORWARD_WIDTH    = 2,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_REG_FILE = 2'b00,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_WB       = 2'b01,
   parameter logic [REG_FORWARD_WIDTH-1:0] REG_FORWARD_R0       = 2'b10,
   parameter int unsigned                 STALL_CNT_WIDTH      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   input  logic                         id_use_1,
   input  logic                         id_use_2,
   input  logic [REG_NUM_WIDTH-1:0]     rn_1,
   input  logic [REG_NUM_WIDTH-1:0]     rn_2,
   input  logic                         id_wr,
   input  logic [REG_NUM_WIDTH-1:0]     id_wrn,
   input  logic                         id_wr0,
   input  logic                         flush,
   output logic [REG_FORWARD_WIDTH-1:0] reg_forward_1,
   output logic [REG_FORWARD_WIDTH-1:0] reg_forward_2,
   output logic                         stall,
   output logic                         wb_wr,
   output logic                         wb_wr0,
   output logic [REG_NUM_WIDTH-1:0]     wb_wrn,
   output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
);

   typedef struct packed {
      logic                     valid;
      logic                     wr;
      logic [REG_NUM_WIDTH-1:0] wrn;
      logic                     wr0;
   } slot_t;

   slot_t                      ex_q, mem_q, wb_q;
   slot_t                      ex_d, mem_d;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
   logic                       hazard;

   // A source matches a slot when it reads the general register the slot
   // writes, or reads register 0 while the slot writes the dedicated R0 port.
   function automatic logic src_match(input slot_t                    s,
                                      input logic                     use_src,
                                      input logic [REG_NUM_WIDTH-1:0] rn);
      return s.valid & use_src & ((s.wr & (s.wrn == rn)) | (s.wr0 & (rn == '0)));
   endfunction

   // The R0 port is checked first: when WB writes register 0 through both
   // ports the register file keeps the R0 data, so the bypass must too.
   function automatic logic [REG_FORWARD_WIDTH-1:0] fwd_sel(
         input slot_t                    s,
         input logic                     use_src,
         input logic [REG_NUM_WIDTH-1:0] rn);
      if (s.valid && use_src && s.wr0 && (rn == '0))
         return REG_FORWARD_R0;
      else if (s.valid && use_src && s.wr && (s.wrn == rn))
         return REG_FORWARD_WB;
      else
         return REG_FORWARD_REG_FILE;
   endfunction

   assign hazard = src_match(ex_q,  id_use_1, rn_1) | src_match(ex_q,  id_use_2, rn_2) |
                   src_match(mem_q, id_use_1, rn_1) | src_match(mem_q, id_use_2, rn_2);

   // Flush kills the ID instruction, so it must never also be held.
   assign stall = id_valid & hazard & ~flush;

   // Selects are produced every cycle; the register file ignores them when
   // the ID instruction is invalid or stalled.
   assign reg_forward_1 = fwd_sel(wb_q, id_use_1, rn_1);
   assign reg_forward_2 = fwd_sel(wb_q, id_use_2, rn_2);

   assign wb_wr     = wb_q.valid & wb_q.wr;
   assign wb_wr0    = wb_q.valid & wb_q.wr0;
   assign wb_wrn    = wb_q.wrn;
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, so
      // no path can leave it unassigned and infer a latch.
      ex_d  = '0;
      mem_d = ex_q;
      if (id_valid && !stall && !flush)
         ex_d = '{valid: 1'b1, wr: id_wr, wrn: id_wrn, wr0: id_wr0};
      // The instruction in EX is on the wrong path of a taken branch.
      if (flush)
         mem_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= mem_q;
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_ctrl
//
// Self-checking bench for fwd_ctrl. The reference model keeps a history of
// issued instructions tagged with their issue cycle. An instruction issued in
// cycle c is in EX at c+1, in MEM at c+2 and in WB at c+3, unless a flush
// removed it. Expected outputs are derived from that history. Directed
// scenarios add fixed expected values on top of the model.
//
// The stall counter is built 10 bits wide so saturation is reached in a
// short run. The saturation logic does not depend on the width.
// ---------------------------------------------------------------------------
module tb_fwd_ctrl;

   localparam int unsigned CNT_W   = 10;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid, id_use_1, id_use_2, id_wr, id_wr0, flush;
   logic [3:0]       rn_1, rn_2, id_wrn;
   logic [1:0]       reg_forward_1, reg_forward_2;
   logic             stall, wb_wr, wb_wr0;
   logic [3:0]       wb_wrn;
   logic [CNT_W-1:0] stall_cnt;

   fwd_ctrl #(.STALL_CNT_WIDTH(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_use_1      (id_use_1),
      .id_use_2      (id_use_2),
      .rn_1          (rn_1),
      .rn_2          (rn_2),
      .id_wr         (id_wr),
      .id_wrn        (id_wrn),
      .id_wr0        (id_wr0),
      .flush         (flush),
      .reg_forward_1 (reg_forward_1),
      .reg_forward_2 (reg_forward_2),
      .stall         (stall),
      .wb_wr         (wb_wr),
      .wb_wr0        (wb_wr0),
      .wb_wrn        (wb_wrn),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int         c;
      logic       wr;
      logic [3:0] wrn;
      logic       wr0;
      bit         killed;
   } rec_t;

   rec_t hist[$];
   int   cyc   = 0;
   int   m_cnt = 0;
   bit   e_stall;

   int passed = 0;
   int total  = 0;

   // Outputs observed at the most recent sample point.
   logic             s_stall, s_wbwr, s_wbwr0;
   logic [1:0]       s_f1, s_f2;
   logic [3:0]       s_wbwrn;
   logic [CNT_W-1:0] s_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic bit in_stage(input int age, output rec_t r);
      r = '{default: 0};
      foreach (hist[i])
         if (hist[i].c == cyc - age && !hist[i].killed) begin
            r = hist[i];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic bit reads(input rec_t r, input logic u, input logic [3:0] rn);
      return u && ((r.wr && r.wrn == rn) || (r.wr0 && rn == 4'd0));
   endfunction

   function automatic logic [1:0] exp_fwd(input bit ok, input rec_t r,
                                          input logic u, input logic [3:0] rn);
      if (ok && u && r.wr0 && rn == 4'd0) return 2'b10;
      if (ok && u && r.wr && r.wrn == rn) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check_model();
      rec_t ex, mem, wb;
      bit   ok_ex, ok_mem, ok_wb, hz;
      ok_ex  = in_stage(1, ex);
      ok_mem = in_stage(2, mem);
      ok_wb  = in_stage(3, wb);
      hz = (ok_ex  && (reads(ex,  id_use_1, rn_1) || reads(ex,  id_use_2, rn_2))) ||
           (ok_mem && (reads(mem, id_use_1, rn_1) || reads(mem, id_use_2, rn_2)));
      e_stall = id_valid && hz && !flush;
      chk("stall",  32'(s_stall), 32'(e_stall));
      chk("fwd_1",  32'(s_f1),    32'(exp_fwd(ok_wb, wb, id_use_1, rn_1)));
      chk("fwd_2",  32'(s_f2),    32'(exp_fwd(ok_wb, wb, id_use_2, rn_2)));
      chk("wb_wr",  32'(s_wbwr),  32'(ok_wb && wb.wr));
      chk("wb_wr0", 32'(s_wbwr0), 32'(ok_wb && wb.wr0));
      if (ok_wb && wb.wr)
         chk("wb_wrn", 32'(s_wbwrn), 32'(wb.wrn));
      chk("stall_cnt", 32'(s_cnt), 32'(m_cnt));
   endtask

   // Model state change at the rising edge that ends the current cycle.
   task automatic update_model();
      if (rst) begin
         hist.delete();
         m_cnt = 0;
      end else begin
         if (flush)
            foreach (hist[i])
               if (hist[i].c == cyc - 1) hist[i].killed = 1'b1;
         if (e_stall && m_cnt < CNT_MAX) m_cnt++;
         if (id_valid && !e_stall && !flush)
            hist.push_back('{c: cyc, wr: id_wr, wrn: id_wrn, wr0: id_wr0, killed: 1'b0});
      end
      while (hist.size() > 0 && hist[0].c < cyc - 3) void'(hist.pop_front());
      cyc++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic v, input logic u1, input logic [3:0] r1,
                       input logic u2, input logic [3:0] r2, input logic w,
                       input logic [3:0] wn, input logic w0, input logic fl);
      @(negedge clk);
      rst = 1'b0; id_valid = v; id_use_1 = u1; rn_1 = r1; id_use_2 = u2; rn_2 = r2;
      id_wr = w; id_wrn = wn; id_wr0 = w0; flush = fl;
      #1;
      s_stall = stall; s_f1 = reg_forward_1; s_f2 = reg_forward_2;
      s_wbwr = wb_wr; s_wbwr0 = wb_wr0; s_wbwrn = wb_wrn; s_cnt = stall_cnt;
      check_model();
      @(posedge clk);
      update_model();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic rand_inputs();
      id_valid = ($urandom_range(3) != 0);
      id_use_1 = 1'($urandom); rn_1 = 4'($urandom_range(3));
      id_use_2 = 1'($urandom); rn_2 = 4'($urandom_range(3));
      id_wr    = 1'($urandom); id_wrn = 4'($urandom_range(3));
      id_wr0   = ($urandom_range(3) == 0);
      flush    = ($urandom_range(7) == 0);
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b1;
         rand_inputs();
         @(posedge clk);
         update_model();
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1;
      id_valid = 1'b0; id_use_1 = 1'b0; id_use_2 = 1'b0; rn_1 = '0; rn_2 = '0;
      id_wr = 1'b0; id_wrn = '0; id_wr0 = 1'b0; flush = 1'b0;

      // Reset with random inputs, then look at the settled outputs.
      do_reset(2);
      step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
           1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      chk("rst_stall",  32'(s_stall), 32'd0);
      chk("rst_wb_wr",  32'(s_wbwr),  32'd0);
      chk("rst_wb_wr0", 32'(s_wbwr0), 32'd0);
      chk("rst_wb_wrn", 32'(s_wbwrn), 32'd0);
      chk("rst_cnt",    32'(s_cnt),   32'd0);
      chk("rst_fwd_1",  32'(s_f1),    32'd0);
      chk("rst_fwd_2",  32'(s_f2),    32'd0);
      idle();

      // RAW distance 1: writer of R3, then a reader of R3 held in ID.
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("raw1_stall_a", 32'(s_stall), 32'd1);
      step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("raw1_stall_b", 32'(s_stall), 32'd1);
      step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("raw1_stall_c", 32'(s_stall), 32'd0);
      chk("raw1_fwd_1",   32'(s_f1),    32'b01);
      chk("raw1_wb_wr",   32'(s_wbwr),  32'd1);
      chk("raw1_wb_wrn",  32'(s_wbwrn), 32'd3);
      chk("raw1_cnt",     32'(s_cnt),   32'd2);
      idle(); idle(); idle();

      // R0 port at distance 3, consumer reads R0 and then R5.
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
         idle(); idle();
         step(1'b1, 1'b0, 4'd0, 1'b1, (k == 0) ? 4'd0 : 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
         chk("r0_stall",  32'(s_stall), 32'd0);
         chk("r0_fwd_2",  32'(s_f2),    (k == 0) ? 32'b10 : 32'b00);
         chk("r0_wb_wr0", 32'(s_wbwr0), 32'd1);
         idle(); idle(); idle();
      end

      // Dual write of register 0: the R0 port wins.
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
      idle(); idle();
      step(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("dual_fwd_1", 32'(s_f1), 32'b10);
      idle(); idle(); idle();

      // Flush while the R4 writer is in EX.
      begin
         logic [CNT_W-1:0] cnt_ref;
         step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0);
         step(1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
         chk("flush_stall", 32'(s_stall), 32'd0);
         cnt_ref = s_cnt;
         for (int k = 0; k < 3; k++) begin
            idle();
            chk("flush_wb_wr", 32'(s_wbwr), 32'd0);
         end
         chk("flush_cnt", 32'(s_cnt), 32'(cnt_ref));
      end

      // Random traffic with occasional mid-operation resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(49) == 0) begin
            do_reset(1);
         end else begin
            logic v, u1, u2, w, w0, fl;
            logic [3:0] r1, r2, wn;
            v  = ($urandom_range(3) != 0);
            u1 = 1'($urandom); r1 = 4'($urandom_range(3));
            u2 = 1'($urandom); r2 = 4'($urandom_range(3));
            w  = 1'($urandom); wn = 4'($urandom_range(3));
            w0 = ($urandom_range(3) == 0);
            fl = ($urandom_range(7) == 0);
            step(v, u1, r1, u2, r2, w, wn, w0, fl);
         end
      end

      // Counter saturation: a self-dependent instruction held in ID stalls
      // two cycles out of every three.
      do_reset(2);
      for (int n = 0; n < (CNT_MAX * 3) / 2 + 60; n++)
         step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
      chk("sat_cnt", 32'(s_cnt), 32'(CNT_MAX));
      for (int n = 0; n < 6; n++)
         step(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
      chk("sat_cnt_hold", 32'(s_cnt), 32'(CNT_MAX));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
